// File: rtl/writeback_stage_if.sv
// Upstream (MEM -> WB) handshake and instruction fields for the writeback stage.
// The master side is the MEM stage; the slave side is writeback_stage.
interface writeback_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic              in_we;
    logic [1:0]        in_wbsel;
    logic [2:0]        in_funct3;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_pc4;

    modport master (
        output in_valid, in_rd, in_we, in_wbsel, in_funct3, in_alu, in_pc4,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_we, in_wbsel, in_funct3, in_alu, in_pc4,
        output in_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Single-entry writeback stage: holds one instruction, waits for load data when
// needed, formats the result and drives the register-file write port.
module writeback_stage #(
    parameter int          DATA_W       = 32,
    parameter logic [31:0] INSTRET_INIT = 32'h0  // reset value of instret; keep 0 in real use
) (
    input  logic              clk,
    input  logic              reset,
    writeback_stage_if.slave  up,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic [4:0]        rd,
    output logic              we,
    output logic [DATA_W-1:0] wrs3,
    output logic [31:0]       instret
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_MEM = 2'd2
    } state_t;

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]        rd;
        logic              we;
        logic [1:0]        wbsel;
        logic [2:0]        funct3;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] pc4;
    } stage_t;

    state_t            state, state_nxt;
    stage_t            stage_q, stage_d;
    logic              retire;
    logic              accept;
    logic              ready;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result;

    // Next-state and handshake. Flush dominates everything in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        stage_d   = stage_q;
        retire    = 1'b0;

        case (state)
            IDLE:     retire = 1'b0;
            HOLD:     retire = 1'b1;
            WAIT_MEM: retire = mem_rvalid;
            default:  retire = 1'b0;
        endcase

        if (flush) begin
            retire = 1'b0;
        end

        ready  = reset & ~flush & ((state == IDLE) | retire);
        accept = up.in_valid & ready;

        if (flush) begin
            state_nxt = IDLE;
            stage_d   = '0;
        end else if (accept) begin
            state_nxt      = (up.in_wbsel == WB_LOAD) ? WAIT_MEM : HOLD;
            stage_d.rd     = up.in_rd;
            stage_d.we     = up.in_we;
            stage_d.wbsel  = up.in_wbsel;
            stage_d.funct3 = up.in_funct3;
            stage_d.alu    = up.in_alu;
            stage_d.pc4    = up.in_pc4;
        end else if (retire || (state != HOLD && state != WAIT_MEM)) begin
            state_nxt = IDLE;
        end
    end

    assign up.in_ready = ready;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state   <= IDLE;
            stage_q <= '0;
            instret <= INSTRET_INIT;
        end else begin
            state   <= state_nxt;
            stage_q <= stage_d;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

    // Load formatting: the memory returns an aligned word, the low address bits pick the lane.
    always_comb begin
        case (stage_q.alu[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase

        ld_half = stage_q.alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (stage_q.funct3)
            F3_LB:   load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, ld_byte};
            F3_LH:   load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase

        case (stage_q.wbsel)
            WB_LOAD: result = load_data;
            WB_PC4:  result = stage_q.pc4;
            default: result = stage_q.alu;
        endcase
    end

    // Write port is quiet outside retire cycles; x0 retires but never writes.
    always_comb begin
        rd   = '0;
        we   = 1'b0;
        wrs3 = '0;
        if (retire) begin
            rd   = stage_q.rd;
            we   = stage_q.we & (stage_q.rd != 5'd0);
            wrs3 = result;
        end
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-004 in_valid  in  1  upstream (MEM) holds a valid instruction.
REQ-005 in_ready  out  1  stage can accept; transfer when in_valid & in_ready at rising clk.
REQ-006 in_rd  in  5  destination register index.
REQ-007 in_we  in  1  instruction writes a register.
REQ-008 in_wbsel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
REQ-009 in_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 in_alu  in  32  ALU result; low 2 bits are load byte offset.
REQ-011 in_pc4  in  32  PC+4 of instruction.
REQ-012 mem_rdata  in  32  aligned word from data memory.
REQ-013 mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-014 flush  in  1  discard held instruction.
REQ-015 rd  out  5  register file write index.
REQ-016 we  out  1  register file write enable.
REQ-017 wrs3  out  32  register file write data.
REQ-018 instret  out  32  count of retired instructions.

Function
REQ-019 The block SHALL hold at most one instruction in a stage register; states IDLE, HOLD, WAIT_MEM.
REQ-020 IDLE: accept on in_valid -> HOLD (non-load) or WAIT_MEM (in_wbsel=01).
REQ-021 HOLD: the instruction SHALL retire in that cycle; next state from simultaneous accept, else IDLE.
REQ-022 WAIT_MEM: retire in the cycle mem_rvalid=1, then as HOLD; otherwise stay, with mem_rdata ignored.
REQ-023 in_ready SHALL be 1 in IDLE, 1 in a retiring cycle, 0 in WAIT_MEM without mem_rvalid, 0 whenever flush=1.
REQ-024 Retire cycle: rd = held in_rd; wrs3 = selected result; we = held in_we & (rd != 0); outputs combinational from stage register and mem_rdata.
REQ-025 Non-retiring cycles SHALL drive we=0, rd=0, wrs3=0.
REQ-026 Writes to x0 SHALL be suppressed (we=0) but still retire and count.
REQ-027 LB/LBU: byte selected by in_alu[1:0], sign- or zero-extended to 32 bits.
REQ-028 LH/LHU: halfword selected by in_alu[1] (0 -> bits 15:0, 1 -> bits 31:16), sign/zero-extended; in_alu[0] ignored.
REQ-029 LW and funct3 011/110/111: wrs3 = mem_rdata unchanged.
REQ-030 PC+4 select: wrs3 = held in_pc4; ALU select: wrs3 = held in_alu.
REQ-031 instret SHALL increment by 1 per retire, wrap 0xFFFFFFFF -> 0, and not count flushed instructions.
REQ-032 flush=1 SHALL clear the stage to IDLE at the next edge with no retire, no we, and no accept, overriding mem_rvalid and in_valid in the same cycle.
REQ-033 mem_rvalid in IDLE or HOLD SHALL have no effect.
REQ-034 Throughput: one non-load instruction per cycle back-to-back; one-cycle latency from accept to retire.

Reset
REQ-035 While reset=0: state IDLE, stage register cleared, we=0, rd=0, wrs3=0, instret=0, in_ready=0.
REQ-036 Reset asserted in WAIT_MEM SHALL abandon the load; after release, the first cycle is IDLE with in_ready=1.

Verification
REQ-037 Accept ALU op rd=5, alu=0x1234 -> next cycle we=1, rd=5, wrs3=0x00001234, instret 0->1.
REQ-038 LB, alu[1:0]=3, mem_rdata=0x80FF_0000 arriving 3 cycles late -> in_ready=0 for 3 cycles, then wrs3=0xFFFFFF80; LHU, alu[1]=1, same data -> 0x000080FF.
REQ-039 rd=0 ALU op -> we=0, instret increments.
REQ-040 flush during WAIT_MEM with mem_rvalid=1 that same cycle -> no write, instret unchanged, state IDLE.
REQ-041 Back-to-back 4 ALU ops, in_valid held 1 -> 4 consecutive write cycles; instret preset near 0xFFFFFFFE wraps to 0x00000002.
REQ-042 reset pulsed low mid-WAIT_MEM -> all outputs 0 immediately, instret=0.
